// File: rtl/fifo_pkg.sv
// Shared types for the async FIFO read-side output stage.
// State encoding doubles as the buffered word count.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } rd_stage_state_t;

    localparam int RD_STAGE_DEPTH = 2;
    localparam int RD_LEVEL_W     = $clog2(RD_STAGE_DEPTH + 1);

    function automatic logic [RD_LEVEL_W-1:0] state_level(
        input rd_stage_state_t s
    );
        logic [RD_LEVEL_W-1:0] l;
        l = '0;
        case (s)
            ONE:     l = RD_LEVEL_W'(1);
            TWO:     l = RD_LEVEL_W'(2);
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/fifo_rd_stage.sv
// Read-side output stage: pops the FIFO head into a 2-entry skid buffer.
// Optional synchronous buffer flush port under FIFO_RD_STAGE_FLUSH_EN.
module fifo_rd_stage
    import fifo_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
`ifdef FIFO_RD_STAGE_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  rempty,
    input  logic [DATASIZE-1:0]   rdata,
    output logic                  rinc,
    output logic                  out_valid,
    output logic [DATASIZE-1:0]   out_data,
    input  logic                  out_ready,
    output logic [RD_LEVEL_W-1:0] level
);

    rd_stage_state_t     state_q;
    rd_stage_state_t     state_n;
    logic [DATASIZE-1:0] skid_q;
    logic [DATASIZE-1:0] skid_n;
    logic [DATASIZE-1:0] data_n;
    logic                clr;
    logic                fetch;
    logic                pop;

`ifdef FIFO_RD_STAGE_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // Fetch depends only on registered state and rempty, never out_ready.
    assign fetch = rrst_n & ~rempty & (state_q != TWO) & ~clr;
    assign pop   = out_valid & out_ready & ~clr;
    assign rinc  = fetch;

    always_comb begin
        state_n = state_q;
        data_n  = out_data;
        skid_n  = skid_q;
        case (state_q)
            ONE: begin
                unique case (1'b1)
                    fetch & ~pop: begin
                        state_n = TWO;
                        skid_n  = rdata;
                    end
                    fetch & pop: begin
                        state_n = ONE;
                        data_n  = rdata;
                    end
                    ~fetch & pop: begin
                        state_n = EMPTY;
                    end
                    default: begin
                        state_n = ONE;
                    end
                endcase
            end
            TWO: begin
                if (pop) begin
                    state_n = ONE;
                    data_n  = skid_q;
                end
            end
            default: begin
                // EMPTY and any illegal encoding behave as EMPTY.
                state_n = EMPTY;
                if (fetch) begin
                    state_n = ONE;
                    data_n  = rdata;
                end
            end
        endcase
        if (clr) begin
            state_n = EMPTY;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_q    <= '0;
            level     <= '0;
        end else begin
            state_q   <= state_n;
            out_valid <= (state_n != EMPTY);
            out_data  <= data_n;
            skid_q    <= skid_n;
            level     <= state_level(state_n);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Directed self-checking bench for fifo_rd_stage.
// A small array models the FIFO head driving rempty/rdata.
module tb_fifo_rd_stage;

    logic       rclk;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] level;
    logic       flush;

    logic [7:0] mem [0:31];
    int         head;
    int         tail;
    int         checks;
    int         errors;

    fifo_rd_stage #(.DATASIZE(8)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
`ifdef FIFO_RD_STAGE_FLUSH_EN
        .flush     (flush),
`endif
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign rempty = (head >= tail);
    assign rdata  = mem[head[4:0]];

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)
            head <= 0;
        else if (rinc)
            head <= head + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        tail      = 0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rrst_n    = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_level", {30'd0, level}, 0);
        chk("rst_data", {24'd0, out_data}, 0);
        chk("rst_rinc", {31'd0, rinc}, 0);
        rrst_n = 1'b1;
        tick();
        chk("idle_level", {30'd0, level}, 0);
        chk("idle_rinc", {31'd0, rinc}, 0);
        out_ready = 1'b1;
        tick();
        chk("idle_rdy_valid", {31'd0, out_valid}, 0);

        // Streaming 0x01..0x10 with out_ready held high.
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
        tail = 16;
        #1;
        chk("st_rinc0", {31'd0, rinc}, 1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("st_data", {24'd0, out_data}, k);
            chk("st_level", {30'd0, level}, 1);
            chk("st_rinc", {31'd0, rinc}, (k < 16) ? 1 : 0);
        end
        tick();
        chk("st_end_valid", {31'd0, out_valid}, 0);
        chk("st_end_level", {30'd0, level}, 0);

        // Backpressure: two fetches then stall.
        out_ready = 1'b0;
        mem[16] = 8'hA0;
        mem[17] = 8'hA1;
        mem[18] = 8'hA2;
        tail = 19;
        tick();
        chk("bp1_level", {30'd0, level}, 1);
        chk("bp1_data", {24'd0, out_data}, 8'hA0);
        chk("bp1_rinc", {31'd0, rinc}, 1);
        tick();
        chk("bp2_level", {30'd0, level}, 2);
        chk("bp2_rinc", {31'd0, rinc}, 0);
        tick();
        chk("bp3_level", {30'd0, level}, 2);
        chk("bp3_data", {24'd0, out_data}, 8'hA0);
        chk("bp3_head", head, 18);
        out_ready = 1'b1;
        #1;
        chk("bp_no_comb_rinc", {31'd0, rinc}, 0);
        tick();
        chk("bp4_data", {24'd0, out_data}, 8'hA1);
        chk("bp4_level", {30'd0, level}, 1);
        chk("bp4_rinc", {31'd0, rinc}, 1);
        tick();
        chk("bp5_data", {24'd0, out_data}, 8'hA2);
        chk("bp5_level", {30'd0, level}, 1);
        tick();
        chk("bp6_valid", {31'd0, out_valid}, 0);

        // Drain to empty from a single 0x55.
        out_ready = 1'b0;
        mem[19] = 8'h55;
        tail = 20;
        tick();
        chk("dr_data", {24'd0, out_data}, 8'h55);
        chk("dr_level1", {30'd0, level}, 1);
        out_ready = 1'b1;
        #1;
        chk("dr_rinc", {31'd0, rinc}, 0);
        tick();
        chk("dr_valid", {31'd0, out_valid}, 0);
        chk("dr_level0", {30'd0, level}, 0);

        // Simultaneous pop and fetch in ONE.
        out_ready = 1'b0;
        mem[20] = 8'h33;
        mem[21] = 8'h34;
        tail = 22;
        tick();
        chk("sim_data0", {24'd0, out_data}, 8'h33);
        out_ready = 1'b1;
        tick();
        chk("sim_data1", {24'd0, out_data}, 8'h34);
        chk("sim_level", {30'd0, level}, 1);
        tick();
        chk("sim_empty", {31'd0, out_valid}, 0);

        // Reset mid-transfer at level 2.
        out_ready = 1'b0;
        mem[22] = 8'hC0;
        mem[23] = 8'hC1;
        mem[24] = 8'hC2;
        tail = 25;
        tick();
        tick();
        chk("mr_level2", {30'd0, level}, 2);
        rrst_n = 1'b0;
        tail   = 0;
        #1;
        chk("mr_valid", {31'd0, out_valid}, 0);
        chk("mr_level", {30'd0, level}, 0);
        chk("mr_rinc", {31'd0, rinc}, 0);
        tick();
        rrst_n = 1'b1;
        tick();
        chk("mr_post_level", {30'd0, level}, 0);
        chk("mr_post_rinc", {31'd0, rinc}, 0);

`ifdef FIFO_RD_STAGE_FLUSH_EN
        mem[0] = 8'hF0;
        mem[1] = 8'hF1;
        mem[2] = 8'hF2;
        tail = 3;
        tick();
        tick();
        chk("fl_level2", {30'd0, level}, 2);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("fl_rinc", {31'd0, rinc}, 0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("fl_valid", {31'd0, out_valid}, 0);
        chk("fl_level0", {30'd0, level}, 0);
        chk("fl_resume", {31'd0, rinc}, 1);
        tick();
        chk("fl_data", {24'd0, out_data}, 8'hF2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
